// File: rtl/prng_byte_packer.sv
// prng_byte_packer: buffers 64-bit words from nlfsr_64 in a small word FIFO
// and serializes them MSB byte first over a valid/ready byte stream.
// Words offered while the FIFO is full are dropped and counted in a
// saturating counter, so captures can be qualified as gap-free or not.
module prng_byte_packer #(
  parameter int DEPTH  = 4,   // word FIFO depth, power of two, >= 2
  parameter int DROP_W = 16   // width of the saturating drop counter
) (
  input  logic                     clk,
  input  logic                     rst,          // async, active-low
  input  logic                     en,
  input  logic [63:0]              prng_in,
  input  logic                     prng_valid,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [63:0]         shift_q, shift_d;
  logic [2:0]          idx_q, idx_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [63:0]         mem_q [DEPTH];

  logic full, empty, push, drop, pop;

  // Full/empty come from the registered level only, so a pop at the same
  // edge never makes room for a push that arrives while full.
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = en & prng_valid & ~full;
  assign drop  = en & prng_valid & full;

  // Shifter FSM: load from FIFO head, emit MSB byte, shift on handshake,
  // and reload on the last byte so consecutive words stream without a bubble.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          idx_d   = 3'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (byte_ready) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            if (!empty) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
            end else begin
              state_d = ST_EMPTY;
            end
          end else begin
            shift_d = {shift_q[55:0], 8'h00};
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // FIFO pointers, occupancy and drop counter next-state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    drop_d = (drop && !(&drop_q)) ? drop_q + DROP_W'(1) : drop_q;
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs, independent of statement order.
    if (!rst) begin
      state_q  <= ST_EMPTY;
      shift_q  <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Word storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy is
    // tracked by the pointers and level, so stale contents are never read.
    if (push) mem_q[wr_ptr_q] <= prng_in;
  end

  assign byte_valid = (state_q == ST_SEND);
  assign byte_out   = byte_valid ? shift_q[63:56] : 8'h00;
  assign fifo_level = level_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_prng_byte_packer.sv
// Directed self-checking bench for prng_byte_packer. A second instance with
// a 4-bit drop counter shares the stimulus to exercise saturation.
module tb_prng_byte_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] prng_in;
  logic        prng_valid;
  logic        byte_ready;

  logic [7:0]  byte_out,   s_byte_out;
  logic        byte_valid, s_byte_valid;
  logic [2:0]  fifo_level, s_fifo_level;
  logic [15:0] drop_count;
  logic [3:0]  s_drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prng_byte_packer #(.DEPTH(4), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .prng_in(prng_in), .prng_valid(prng_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  prng_byte_packer #(.DEPTH(4), .DROP_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .prng_in(prng_in), .prng_valid(prng_valid),
    .byte_out(s_byte_out), .byte_valid(s_byte_valid), .byte_ready(byte_ready),
    .fifo_level(s_fifo_level), .drop_count(s_drop_count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance through one rising edge to the following falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Expects valid on this and the next 7 cycles with byte_ready=1,
  // bytes MSB first.
  task automatic check_word(input string tag, input logic [63:0] w);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s.valid%0d", tag, i), {63'd0, byte_valid}, 64'd1);
      check($sformatf("%s.byte%0d", tag, i), {56'd0, byte_out}, {56'd0, w[63-8*i -: 8]});
      tick();
    end
  endtask

  function automatic logic [63:0] word_k(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {kb, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, ~kb};
  endfunction

  localparam logic [63:0] W0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] W1 = 64'hFEDCBA9876543210;

  initial begin
    // Reset with random inputs
    rst        = 1'b0;
    en         = 1'b1;
    prng_valid = 1'b1;
    prng_in    = {$urandom, $urandom};
    byte_ready = 1'($urandom);
    tick();
    tick();
    check("rst.valid", {63'd0, byte_valid}, 64'd0);
    check("rst.byte",  {56'd0, byte_out},   64'd0);
    check("rst.level", {61'd0, fifo_level}, 64'd0);
    check("rst.drop",  {48'd0, drop_count}, 64'd0);

    // Single word
    prng_valid = 1'b0;
    byte_ready = 1'b1;
    rst        = 1'b1;
    tick();
    prng_in    = W0;
    prng_valid = 1'b1;
    tick();                                  // E0: push
    prng_valid = 1'b0;
    check("single.novalid_e0", {63'd0, byte_valid}, 64'd0);
    check("single.level_e0",   {61'd0, fifo_level}, 64'd1);
    tick();                                  // E1: pop
    check("single.level_e1",   {61'd0, fifo_level}, 64'd0);
    check_word("single", W0);
    check("single.idle", {63'd0, byte_valid}, 64'd0);

    // Backpressure
    byte_ready = 1'b0;
    prng_in    = W0;
    prng_valid = 1'b1;
    tick();
    prng_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.hold_valid%0d", i), {63'd0, byte_valid}, 64'd1);
      check($sformatf("bp.hold_byte%0d", i),  {56'd0, byte_out},   64'h01);
      tick();
    end
    byte_ready = 1'b1;
    check_word("bp", W0);
    check("bp.idle", {63'd0, byte_valid}, 64'd0);

    // Overflow: 10 offered words, 5 accepted (1 shifter + 4 FIFO), 5 dropped
    byte_ready = 1'b0;
    prng_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      prng_in = word_k(k);
      tick();
    end
    prng_valid = 1'b0;
    check("ovf.level",     {61'd0, fifo_level},   64'd4);
    check("ovf.drop",      {48'd0, drop_count},   64'd5);
    check("ovf.drop_sat",  {60'd0, s_drop_count}, 64'd5);
    check("ovf.head_byte", {56'd0, byte_out},     64'h01);
    byte_ready = 1'b1;
    for (int k = 1; k <= 5; k++) check_word($sformatf("ovf.w%0d", k), word_k(k));
    check("ovf.idle",  {63'd0, byte_valid}, 64'd0);
    check("ovf.empty", {61'd0, fifo_level}, 64'd0);

    // Back-to-back drain of 3 queued words, no idle cycles
    byte_ready = 1'b0;
    prng_valid = 1'b1;
    for (int k = 11; k <= 13; k++) begin
      prng_in = word_k(k);
      tick();
    end
    prng_valid = 1'b0;
    check("b2b.level", {61'd0, fifo_level}, 64'd2);
    byte_ready = 1'b1;
    for (int k = 11; k <= 13; k++) check_word($sformatf("b2b.w%0d", k), word_k(k));
    check("b2b.idle", {63'd0, byte_valid}, 64'd0);

    // Saturation: 30 offered, 5 accepted, 25 more drops
    byte_ready = 1'b0;
    prng_valid = 1'b1;
    for (int k = 20; k < 50; k++) begin
      prng_in = word_k(k);
      tick();
    end
    prng_valid = 1'b0;
    check("sat.drop_wide", {48'd0, drop_count},   64'd30);
    check("sat.drop_sat",  {60'd0, s_drop_count}, 64'hF);
    check("sat.level",     {61'd0, fifo_level},   64'd4);

    // Mid-word reset between edges
    byte_ready = 1'b1;
    tick();
    tick();
    tick();
    check("mid.byte3", {56'd0, byte_out}, {56'd0, word_k(20)[39:32]});
    #2 rst = 1'b0;
    #1;
    check("mid.rst_valid", {63'd0, byte_valid},   64'd0);
    check("mid.rst_byte",  {56'd0, byte_out},     64'd0);
    check("mid.rst_level", {61'd0, fifo_level},   64'd0);
    check("mid.rst_drop",  {48'd0, drop_count},   64'd0);
    check("mid.rst_sdrop", {60'd0, s_drop_count}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    check("mid.quiet", {63'd0, byte_valid}, 64'd0);
    prng_in    = W1;
    prng_valid = 1'b1;
    tick();
    prng_valid = 1'b0;
    tick();
    check_word("mid.new", W1);
    check("mid.idle", {63'd0, byte_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
